// File: rtl/apb_cmd_sequencer.sv
// rtl/apb_cmd_sequencer.sv - APB master that executes WRITE/READ/POLL/WAIT commands
//
// Takes one command at a time from a valid/ready command port and turns it into
// APB transfers toward the configuration register bank.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only while idle and not in reset)
//   cmd_op                00 WRITE, 01 READ, 10 POLL, 11 WAIT
//   cmd_addr              register address (unused for WAIT)
//   cmd_data              WRITE data / POLL bit mask / WAIT cycle count
//   rsp_valid             one-cycle completion pulse
//   rsp_data              last read data (READ/POLL), 0 for WRITE/WAIT/timeout
//   rsp_err               timeout or poll exhausted, qualified by rsp_valid
//   busy                  sequencer not idle
//   PADDR..PREADY         APB master interface
module apb_cmd_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 16,
    parameter int MAX_POLLS = 1024,
    parameter int POLL_GAP  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_POLL  = 2'b10;
    localparam logic [1:0] OP_WAIT  = 2'b11;

    // Degenerate parameter values are clamped to one cycle / one poll so the
    // counters always have a meaningful terminal value.
    localparam int TMO_CYC  = (TIMEOUT   < 1) ? 1 : TIMEOUT;
    localparam int POLL_CYC = (MAX_POLLS < 1) ? 1 : MAX_POLLS;
    localparam int GAP_CYC  = (POLL_GAP  < 1) ? 1 : POLL_GAP;
    localparam int TMO_W    = $clog2(TMO_CYC + 1);
    localparam int POLL_W   = $clog2(POLL_CYC + 1);
    localparam int GAP_W    = $clog2(GAP_CYC + 1);

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TMO_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_CYC - 1);
    localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_CYC);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_GAP,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t              state_q,    state_d;
    logic [1:0]          op_q,       op_d;
    logic [DATA_W-1:0]   data_q,     data_d;
    logic [TMO_W-1:0]    tmo_cnt_q,  tmo_cnt_d;
    logic [POLL_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q,  gap_cnt_d;
    logic [DATA_W-1:0]   wait_cnt_q, wait_cnt_d;

    logic                psel_q,     psel_d;
    logic                penable_q,  penable_d;
    logic                pwrite_q,   pwrite_d;
    logic [ADDR_W-1:0]   paddr_q,    paddr_d;
    logic [DATA_W-1:0]   pwdata_q,   pwdata_d;

    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q,   rsp_err_d;
    logic [DATA_W-1:0]   rsp_data_q,  rsp_data_d;
    logic                busy_q,      busy_d;

    assign cmd_ready = (state_q == ST_IDLE) & ~reset;

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

    // All outputs are registered, so every output flop is loaded with the
    // value belonging to the state being entered (state_d), not state_q.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        tmo_cnt_d  = tmo_cnt_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        wait_cnt_d = wait_cnt_q;
        psel_d     = psel_q;
        penable_d  = penable_q;
        pwrite_d   = pwrite_q;
        paddr_d    = paddr_q;
        pwdata_d   = pwdata_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d       = cmd_op;
                    data_d     = cmd_data;
                    tmo_cnt_d  = '0;
                    poll_cnt_d = '0;
                    if (cmd_op == OP_WAIT) begin
                        state_d    = ST_WAIT;
                        // A zero count still spends one cycle in WAIT.
                        wait_cnt_d = (cmd_data == '0) ? DATA_W'(1) : cmd_data;
                    end else begin
                        state_d   = ST_SETUP;
                        psel_d    = 1'b1;
                        penable_d = 1'b0;
                        paddr_d   = cmd_addr;
                        pwrite_d  = (cmd_op == OP_WRITE);
                        pwdata_d  = (cmd_op == OP_WRITE) ? cmd_data : '0;
                    end
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                tmo_cnt_d = '0;
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    case (op_q)
                        OP_WRITE: begin
                            state_d    = ST_RESP;
                            rsp_data_d = '0;
                        end
                        OP_READ: begin
                            state_d    = ST_RESP;
                            rsp_data_d = PRDATA;
                        end
                        OP_POLL: begin
                            if ((PRDATA & data_q) != '0) begin
                                state_d    = ST_RESP;
                                rsp_data_d = PRDATA;
                            end else begin
                                poll_cnt_d = poll_cnt_q + POLL_W'(1);
                                if (poll_cnt_q >= POLL_LAST) begin
                                    state_d    = ST_RESP;
                                    rsp_err_d  = 1'b1;
                                    rsp_data_d = PRDATA;
                                end else begin
                                    state_d   = ST_GAP;
                                    gap_cnt_d = GAP_INIT;
                                end
                            end
                        end
                        default: begin
                            state_d    = ST_RESP;
                            rsp_data_d = '0;
                        end
                    endcase
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    // Abort on the last allowed stalled ACCESS cycle.
                    if (tmo_cnt_q >= TMO_LAST) begin
                        state_d    = ST_RESP;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                        psel_d     = 1'b0;
                        penable_d  = 1'b0;
                    end
                end
            end

            ST_GAP: begin
                // PADDR/PWRITE/PWDATA still hold the poll read setup values.
                if (gap_cnt_q <= GAP_W'(1)) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end

            ST_WAIT: begin
                if (wait_cnt_q <= DATA_W'(1)) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q - DATA_W'(1);
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == ST_RESP);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            data_q      <= '0;
            tmo_cnt_q   <= '0;
            poll_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            tmo_cnt_q   <= tmo_cnt_d;
            poll_cnt_q  <= poll_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_apb_cmd_sequencer.sv
// tb/tb_apb_cmd_sequencer.sv - self-checking bench for apb_cmd_sequencer
module tb_apb_cmd_sequencer;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int MP  = 8;
    localparam int PG  = 4;

    localparam logic [1:0]  OP_WR   = 2'b00;
    localparam logic [1:0]  OP_RD   = 2'b01;
    localparam logic [1:0]  OP_POLL = 2'b10;
    localparam logic [1:0]  OP_WAIT = 2'b11;
    localparam logic [7:0]  POLL_ADDR = 8'h04;
    localparam logic [31:0] DONE_VAL  = 32'h8000_0005;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          busy;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic          PSEL;
    logic          PENABLE;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_cmd_sequencer #(
        .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .MAX_POLLS(MP), .POLL_GAP(PG)
    ) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    // Configuration slave: register bank with a programmable number of wait
    // states, plus a start/done register whose done value appears after a
    // programmable number of completed reads.
    logic [31:0] mem [256];
    int acc_cnt = 0;
    int poll_reads = 0;
    int slave_w = 1;
    int poll_base = 0;
    int poll_done_after = 0;

    function automatic logic [31:0] init_val(input int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    assign PREADY = PSEL && PENABLE && (acc_cnt >= slave_w);
    assign PRDATA = (PADDR == POLL_ADDR)
                  ? (((poll_reads - poll_base) >= poll_done_after) ? DONE_VAL : 32'h0)
                  : mem[PADDR];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
            acc_cnt    <= 0;
            poll_reads <= 0;
        end else begin
            if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else                            acc_cnt <= 0;
            if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR] <= PWDATA;
            if (PSEL && PENABLE && PREADY && !PWRITE && PADDR == POLL_ADDR)
                poll_reads <= poll_reads + 1;
        end
    end

    // Reference model: register image and command timing from first principles.
    logic [31:0] ref_mem [256];

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    endtask

    task automatic ref_model(input logic [1:0] op, input logic [7:0] addr,
                             input logic [31:0] data, input int w, input int da,
                             output int lat, output logic [31:0] d, output logic e,
                             output int setups, output int accs);
        int n, need, reads;
        if (op == OP_WAIT) begin
            n = (data == 0) ? 1 : int'(data);
            lat = n + 1; d = 0; e = 0; setups = 0; accs = 0;
        end else if (w >= TMO) begin
            lat = TMO + 2; d = 0; e = 1; setups = 1; accs = TMO;
        end else if (op == OP_POLL) begin
            need   = ((DONE_VAL & data) != 0) ? da + 1 : MP + 1;
            reads  = (need < MP) ? need : MP;
            e      = (need > MP);
            d      = ((reads - 1) >= da) ? DONE_VAL : 32'h0;
            lat    = reads * (w + 2) + (reads - 1) * PG + 1;
            setups = reads;
            accs   = reads * (w + 1);
        end else begin
            lat = w + 3; e = 0; setups = 1; accs = w + 1;
            d = (op == OP_RD) ? ref_mem[addr] : 32'h0;
            if (op == OP_WR) ref_mem[addr] = data;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Issue one command and observe it to completion, collecting latency,
    // response and APB protocol statistics.
    task automatic run_cmd(input logic [1:0] op, input logic [7:0] addr,
                           input logic [31:0] data, input int w, input int da,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int setups, output int accs, output int bad);
        int   n;
        int   gap_run;
        logic prev_psel;
        logic done;
        lat = -1; rd = '0; er = 1'b0; setups = 0; accs = 0; bad = 0;
        gap_run = 0; prev_psel = 1'b0; done = 1'b0;
        slave_w = w; poll_done_after = da; poll_base = poll_reads;
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) bad++;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int c = 1; c <= 400 && !done; c++) begin
            if (PSEL && !PENABLE) begin
                setups++;
                if (setups > 1 && gap_run != PG) bad++;
                gap_run = 0;
            end
            if (PSEL && PENABLE) begin
                accs++;
                if (!prev_psel) bad++;
            end
            if (PENABLE && !PSEL) bad++;
            if (PSEL && (PWRITE !== (op == OP_WR) || PADDR !== addr)) bad++;
            if (PSEL && op == OP_WR && PWDATA !== data) bad++;
            if (PSEL && op != OP_WR && PWDATA !== 32'h0) bad++;
            if (!PSEL) gap_run++;
            if (rsp_valid) begin
                lat = c; rd = rsp_data; er = rsp_err; done = 1'b1;
                if (PSEL) bad++;
            end
            prev_psel = PSEL;
            if (!done) @(negedge clk);
        end
        @(negedge clk);
        if (rsp_valid || !cmd_ready) bad++;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  addr;
        logic [31:0] data;
        int          w;
        int          da;
        int          lat;
        logic [31:0] rdata;
        logic        err;
        int          setups;
        int          accs;
    } vec_t;

    vec_t vecs[16];

    initial begin
        #500000;
        $display("FAIL watchdog: sim still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int lat, setups, accs, bad, r, w, da, n_bad;
        int e_lat, e_setups, e_accs;
        logic [31:0] rd, e_rd, data;
        logic [7:0]  addr;
        logic [1:0]  op;
        logic        er, e_er;

        //            op       addr   data          w   da   lat rdata         err set acc
        vecs[0]  = '{OP_WR,   8'h00, 32'h8000_0009, 1,  0,   4, 32'h0,         0,  1,  2};
        vecs[1]  = '{OP_WR,   8'h20, 32'h0000_0020, 1,  0,   4, 32'h0,         0,  1,  2};
        vecs[2]  = '{OP_RD,   8'h20, 32'h0,         1,  0,   4, 32'h0000_0020, 0,  1,  2};
        vecs[3]  = '{OP_POLL, 8'h04, 32'h8000_0000, 1,  3,  25, 32'h8000_0005, 0,  4,  8};
        vecs[4]  = '{OP_WR,   8'h10, 32'h1234_5678, 99, 0,  18, 32'h0,         1,  1, 16};
        vecs[5]  = '{OP_WAIT, 8'h00, 32'd10,        1,  0,  11, 32'h0,         0,  0,  0};
        vecs[6]  = '{OP_WAIT, 8'h00, 32'd0,         1,  0,   2, 32'h0,         0,  0,  0};
        vecs[7]  = '{OP_WAIT, 8'h00, 32'd1,         1,  0,   2, 32'h0,         0,  0,  0};
        vecs[8]  = '{OP_POLL, 8'h04, 32'h8000_0000, 1,  100,53, 32'h0,         1,  8, 16};
        vecs[9]  = '{OP_RD,   8'h00, 32'h0,         0,  0,   3, 32'h8000_0009, 0,  1,  1};
        vecs[10] = '{OP_POLL, 8'h04, 32'h8000_0000, 0,  0,   3, 32'h8000_0005, 0,  1,  1};
        vecs[11] = '{OP_RD,   8'h20, 32'h0,         15, 0,  18, 32'h0000_0020, 0,  1, 16};
        vecs[12] = '{OP_RD,   8'h20, 32'h0,         16, 0,  18, 32'h0,         1,  1, 16};
        vecs[13] = '{OP_POLL, 8'h04, 32'h8000_0000, 1,  7,  53, 32'h8000_0005, 0,  8, 16};
        vecs[14] = '{OP_POLL, 8'h04, 32'h0000_0100, 0,  0,  45, 32'h8000_0005, 1,  8,  8};
        vecs[15] = '{OP_RD,   8'h10, 32'h0,         1,  0,   4, 32'hA500_0010, 0,  1,  2};

        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        ref_init();
        repeat (3) @(negedge clk);
        chk("rst_psel", 32'(PSEL), 0);
        chk("rst_penable", 32'(PENABLE), 0);
        chk("rst_pwrite", 32'(PWRITE), 0);
        chk("rst_paddr", 32'(PADDR), 0);
        chk("rst_pwdata", PWDATA, 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_err", 32'(rsp_err), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cmd_ready", 32'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 1);

        for (int i = 0; i < 16; i++) begin
            run_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, vecs[i].w, vecs[i].da,
                    lat, rd, er, setups, accs, bad);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_rsp_data", i), rd, vecs[i].rdata);
            chk($sformatf("vec%0d_rsp_err", i), 32'(er), 32'(vecs[i].err));
            chk($sformatf("vec%0d_setups", i), 32'(setups), 32'(vecs[i].setups));
            chk($sformatf("vec%0d_access_cycles", i), 32'(accs), 32'(vecs[i].accs));
            chk($sformatf("vec%0d_protocol", i), 32'(bad), 0);
            if (vecs[i].op == OP_WR && !vecs[i].err) ref_mem[vecs[i].addr] = vecs[i].data;
            if (i == 0) chk("slave_reg00", mem[0], 32'h8000_0009);
        end

        // Reset while the second ACCESS cycle of a WRITE is in progress.
        slave_w = 5;
        cmd_valid = 1'b1; cmd_op = OP_WR; cmd_addr = 8'h30; cmd_data = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_in_access", 32'({PSEL, PENABLE}), 32'h3);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_psel", 32'(PSEL), 0);
        chk("midrst_penable", 32'(PENABLE), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_cmd_ready", 32'(cmd_ready), 1);
        n_bad = 0;
        repeat (8) begin
            if (rsp_valid || PSEL || busy) n_bad++;
            @(negedge clk);
        end
        chk("midrst_quiet", 32'(n_bad), 0);
        chk("midrst_no_write", mem[8'h30], init_val(8'h30));
        ref_init();

        // Randomized commands against the reference model.
        for (int k = 0; k < 40; k++) begin
            op = 2'($urandom_range(0, 3));
            r  = $urandom_range(0, 9);
            w  = (r < 7) ? (r % 3) : ((r == 7) ? 15 : 16 + (r % 2));
            da = $urandom_range(0, 9);
            addr = (op == OP_POLL) ? POLL_ADDR : 8'($urandom_range(8, 15) * 4);
            case (op)
                OP_WAIT: data = 32'($urandom_range(0, 12));
                OP_POLL: begin
                    r = $urandom_range(0, 2);
                    data = (r == 0) ? 32'h8000_0000 : ((r == 1) ? 32'h1 : 32'h100);
                end
                default: data = $urandom;
            endcase
            ref_model(op, addr, data, w, da, e_lat, e_rd, e_er, e_setups, e_accs);
            run_cmd(op, addr, data, w, da, lat, rd, er, setups, accs, bad);
            chk($sformatf("rnd%0d_op%0d_latency", k, op), 32'(lat), 32'(e_lat));
            chk($sformatf("rnd%0d_op%0d_rsp_data", k, op), rd, e_rd);
            chk($sformatf("rnd%0d_op%0d_rsp_err", k, op), 32'(er), 32'(e_er));
            chk($sformatf("rnd%0d_op%0d_setups", k, op), 32'(setups), 32'(e_setups));
            chk($sformatf("rnd%0d_op%0d_access_cycles", k, op), 32'(accs), 32'(e_accs));
            chk($sformatf("rnd%0d_op%0d_protocol", k, op), 32'(bad), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
